sr_driver: RTL and testbench

//   Driver end of the SR flip-flop interface: converts requested target bits into
//   s/r excitation for a downstream SR flip-flop, then confirms the result on q_fb.

---
 rtl/sr_driver_if.sv | 19 +
 rtl/sr_driver.sv | 113 +++++++++++
 tb/tb_sr_driver.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sr_driver_if.sv
// Command handshake into the SR flip-flop driver.
// Source drives tgt_valid/tgt; the driver answers with tgt_ready.
interface sr_driver_if;
  logic tgt_valid;
  logic tgt;
  logic tgt_ready;

  modport master (
    output tgt_valid,
    output tgt,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt,
    output tgt_ready
  );
endinterface

// File: rtl/sr_driver.sv
// SR flip-flop driver: turns target bits into s/r pulses and
// confirms the result on q_fb; s and r are never high together.
module sr_driver #(
  parameter int HOLD_CYC = 1,
  parameter int CNT_W    = 8,
  parameter int SKIP_EQ  = 1
) (
  input  logic             clk,
  input  logic             rst,
  sr_driver_if.slave       cmd,
  input  logic             q_fb,
  output logic             s,
  output logic             r,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int HOLD_EFF = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
  localparam int HW = $clog2(HOLD_EFF + 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_EFF);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } state_t;

  state_t state, state_d;
  logic s_d, r_d;
  logic tgt_q, tgt_q_d;
  logic [HW-1:0] hcnt, hcnt_d;
  logic [CNT_W-1:0] cnt_d;
  logic accept;

  assign cmd.tgt_ready = (state == IDLE) & ~rst;
  assign accept = cmd.tgt_valid & cmd.tgt_ready;
  assign busy = (state != IDLE) & ~rst;
  assign done = (state == CHECK) & ~rst;
  assign err = done & (q_fb ^ tgt_q);

  always_comb begin
    state_d = state;
    s_d = s;
    r_d = r;
    hcnt_d = hcnt;
    tgt_q_d = tgt_q;
    cnt_d = err_cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          tgt_q_d = cmd.tgt;
          if (SKIP_EQ != 0 && q_fb == cmd.tgt) begin
            state_d = CHECK;
            s_d = 1'b0;
            r_d = 1'b0;
          end else begin
            state_d = DRIVE;
            s_d = cmd.tgt;
            r_d = ~cmd.tgt;
            hcnt_d = HW'(1);
          end
        end
      end
      DRIVE: begin
        // hcnt counts excitation cycles already on the wire
        if (hcnt == HMAX) begin
          state_d = SETTLE;
          s_d = 1'b0;
          r_d = 1'b0;
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt + 1'b1;
        end
      end
      SETTLE: begin
        state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        if (err && !(&err_cnt)) begin
          cnt_d = err_cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        s_d = 1'b0;
        r_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s <= 1'b0;
      r <= 1'b0;
      hcnt <= '0;
      tgt_q <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_d;
      s <= s_d;
      r <= r_d;
      hcnt <= hcnt_d;
      tgt_q <= tgt_q_d;
      err_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sr_driver.sv
// Bench for sr_driver: unit 0 (HOLD 1, CNT_W 2) and
// unit 1 (HOLD 4, CNT_W 8), each looped back to an SR FF model.
module tb_sr_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] valid = '0;
  logic [1:0] tgt = '0;
  logic [1:0] tie_en = '0;
  logic [1:0] tie_val = '0;
  logic [1:0] qfb, s, r, busy, done, err, ready, ff;
  logic [1:0] ecnt_a;
  logic [7:0] ecnt_b;

  int total = 0;
  int bad = 0;
  bit sbq0[$];
  bit sbq1[$];
  int ndone[2];
  int nacc[2];
  int lat, s_cnt, r_cnt;

  sr_driver_if ifa ();
  sr_driver_if ifb ();

  assign ifa.tgt_valid = valid[0];
  assign ifa.tgt = tgt[0];
  assign ready[0] = ifa.tgt_ready;
  assign ifb.tgt_valid = valid[1];
  assign ifb.tgt = tgt[1];
  assign ready[1] = ifb.tgt_ready;

  assign qfb = (tie_en & tie_val) | (~tie_en & ff);

  // SR flip-flop models fed by the drivers
  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else ff <= s | (ff & ~r);
  end

  sr_driver #(.HOLD_CYC(1), .CNT_W(2), .SKIP_EQ(1)) u_a (
    .clk(clk), .rst(rst), .cmd(ifa), .q_fb(qfb[0]),
    .s(s[0]), .r(r[0]), .busy(busy[0]), .done(done[0]),
    .err(err[0]), .err_cnt(ecnt_a)
  );

  sr_driver #(.HOLD_CYC(4), .CNT_W(8), .SKIP_EQ(1)) u_b (
    .clk(clk), .rst(rst), .cmd(ifb), .q_fb(qfb[1]),
    .s(s[1]), .r(r[1]), .busy(busy[1]), .done(done[1]),
    .err(err[1]), .err_cnt(ecnt_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit e;
    @(posedge clk);
    #1;
    check("sr_excl", 32'(s & r), 0);
    check("ready_busy", 32'(ready & busy), 0);
    check("err_wo_done", 32'(err & ~done), 0);
    if (done[0]) begin
      ndone[0]++;
      check("done_a_expected", 32'(sbq0.size() > 0), 1);
      if (sbq0.size() > 0) begin
        e = sbq0.pop_front();
        check("err_a", 32'(err[0]), 32'(e));
      end
    end
    if (done[1]) begin
      ndone[1]++;
      check("done_b_expected", 32'(sbq1.size() > 0), 1);
      if (sbq1.size() > 0) begin
        e = sbq1.pop_front();
        check("err_b", 32'(err[1]), 32'(e));
      end
    end
  endtask

  task automatic push(input int u, input bit t);
    bit e;
    e = tie_en[u] ? (tie_val[u] != t) : 1'b0;
    if (u == 0) sbq0.push_back(e);
    else sbq1.push_back(e);
  endtask

  task automatic run(input int u, input bit t, input int exp_lat,
                     input int exp_s, input int exp_r);
    valid[u] = 1'b1;
    tgt[u] = t;
    check("ready_pre", 32'(ready[u]), 1);
    push(u, t);
    tick();
    valid[u] = 1'b0;
    lat = 1;
    s_cnt = int'(s[u]);
    r_cnt = int'(r[u]);
    while (!done[u] && lat < 40) begin
      tick();
      lat++;
      s_cnt += int'(s[u]);
      r_cnt += int'(r[u]);
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("s_cycles", 32'(s_cnt), 32'(exp_s));
    check("r_cycles", 32'(r_cnt), 32'(exp_r));
    tick();
    check("ready_post", 32'(ready[u]), 1);
  endtask

  initial begin
    ndone[0] = 0;
    ndone[1] = 0;
    nacc[0] = 0;
    nacc[1] = 0;

    // reset
    rst = 1'b1;
    tick();
    tick();
    check("rst_s", 32'(s), 0);
    check("rst_r", 32'(r), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt_a", 32'(ecnt_a), 0);
    check("rst_cnt_b", 32'(ecnt_b), 0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(ready), 3);

    // loopback set then reset
    run(0, 1'b1, 3, 1, 0);
    check("q_set", 32'(ff[0]), 1);
    run(0, 1'b0, 3, 0, 1);
    check("q_clr", 32'(ff[0]), 0);
    check("cnt_a_clean", 32'(ecnt_a), 0);

    // skip path with q_fb already at target
    tie_en[0] = 1'b1;
    tie_val[0] = 1'b1;
    run(0, 1'b1, 1, 0, 0);
    check("cnt_a_skip", 32'(ecnt_a), 0);

    // q_fb stuck low: every command errors, counter saturates
    tie_val[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run(0, 1'b1, 3, 1, 0);
      check("err_cnt_sat", 32'(ecnt_a), (i < 2) ? 32'(i + 1) : 32'd3);
    end
    tie_en[0] = 1'b0;

    // long hold, then abort by reset in the 2nd drive cycle
    run(1, 1'b1, 6, 4, 0);
    check("q_b_set", 32'(ff[1]), 1);
    valid[1] = 1'b1;
    tgt[1] = 1'b0;
    tick();
    valid[1] = 1'b0;
    check("abort_r1", 32'(r[1]), 1);
    tick();
    check("abort_r2", 32'(r[1]), 1);
    rst = 1'b1;
    tick();
    check("abort_r_drop", 32'(r[1]), 0);
    check("abort_s_drop", 32'(s[1]), 0);
    check("abort_done", 32'(done[1]), 0);
    rst = 1'b0;
    tick();
    check("abort_idle", 32'(ready[1]), 1);
    check("abort_cnt", 32'(ecnt_b), 0);
    repeat (8) tick();
    check("abort_busy", 32'(busy[1]), 0);

    // random traffic on both units
    ndone[0] = 0;
    ndone[1] = 0;
    for (int i = 0; i < 1000; i++) begin
      valid = 2'($urandom);
      tgt = 2'($urandom);
      for (int u = 0; u < 2; u++) begin
        if (valid[u] && ready[u]) begin
          push(u, tgt[u]);
          nacc[u]++;
        end
      end
      tick();
    end
    valid = '0;
    repeat (10) tick();
    check("rand_done_a", 32'(ndone[0]), 32'(nacc[0]));
    check("rand_done_b", 32'(ndone[1]), 32'(nacc[1]));
    check("rand_q_a", 32'(sbq0.size()), 0);
    check("rand_q_b", 32'(sbq1.size()), 0);
    check("rand_some_acc", 32'(nacc[0] > 10 && nacc[1] > 10), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
